fc_engine_param: RTL and testbench

//  Parametrised fully-connected layer engine; generalises the fixed 4x4 FC datapath to N_COL output lanes.

---
 rtl/fc_engine_param.sv | 135 +++++++++++++
 tb/tb_fc_engine_param.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fc_engine_param.sv
// Fully-connected layer engine: streams one activation plus N_COL weights per beat
// into saturating per-lane accumulators and hands one result vector per job downstream.
module fc_engine_param #(
  parameter int N_COL = 4,
  parameter int KW    = 8,
  parameter int DW    = 4,
  parameter int ACC_W = 44,
  parameter int CNT_W = 7
) (
  input  logic                     clk,
  input  logic                     rst_fsm,
  input  logic                     start,
  input  logic [CNT_W:0]           n_in,
  input  logic                     relu_en,
  input  logic [N_COL-1:0]         ckg_cmask,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DW-1:0]            i_data,
  input  logic [N_COL*KW-1:0]      i_kernel,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N_COL*ACC_W-1:0]   o_data,
  output logic                     busy,
  output logic                     done,
  output logic [CNT_W-1:0]         cnt,
  output logic [1:0]               state_dbg
);

  localparam int PW = KW + DW + 1;
  localparam int SW = ACC_W + 1;
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [CNT_W:0]          n_lat;
  logic                    relu_lat;
  logic [N_COL-1:0]        mask_lat;
  logic signed [ACC_W-1:0] acc     [N_COL];
  logic signed [ACC_W-1:0] acc_nxt [N_COL];
  logic signed [ACC_W-1:0] res     [N_COL];
  logic signed [PW-1:0]    prod    [N_COL];
  logic signed [SW-1:0]    sum     [N_COL];
  logic                    job_go;
  logic                    beat;
  logic                    last_beat;

  // Handshakes: a beat transfers on the rising edge where in_valid && in_ready,
  // a result on the edge where out_valid && out_ready; neither ready depends on its valid.
  assign beat      = in_valid && (state == S_ACC);
  assign last_beat = ({1'b0, cnt} == (n_lat - (CNT_W+1)'(1)));
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (!rst_fsm) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    job_go    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start && (n_in != '0)) begin
          job_go    = 1'b1;
          state_nxt = S_ACC;
        end
      end
      S_ACC: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid && last_beat) state_nxt = S_OUT;
      end
      S_OUT: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        if (out_ready) begin
          done      = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // One guard bit above the accumulator detects overflow; the clamped value is what gets stored.
  always_comb begin
    for (int c = 0; c < N_COL; c++) begin
      prod[c] = PW'($signed(i_kernel[c*KW +: KW])) * PW'($signed({1'b0, i_data}));
      sum[c]  = SW'(acc[c]) + SW'(prod[c]);
      if (sum[c][SW-1] != sum[c][SW-2]) acc_nxt[c] = sum[c][SW-1] ? ACC_MIN : ACC_MAX;
      else                              acc_nxt[c] = sum[c][ACC_W-1:0];
      if (mask_lat[c]) acc_nxt[c] = '0;
      res[c] = (mask_lat[c] || (relu_lat && acc_nxt[c][ACC_W-1])) ? '0 : acc_nxt[c];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_fsm) begin
      for (int c = 0; c < N_COL; c++) acc[c] <= '0;
      o_data   <= '0;
      cnt      <= '0;
      n_lat    <= '0;
      relu_lat <= 1'b0;
      mask_lat <= '0;
    end else if (job_go) begin
      for (int c = 0; c < N_COL; c++) acc[c] <= '0;
      n_lat    <= n_in;
      relu_lat <= relu_en;
      mask_lat <= ckg_cmask;
      cnt      <= '0;
    end else if (beat) begin
      for (int c = 0; c < N_COL; c++) acc[c] <= acc_nxt[c];
      if (last_beat) begin
        cnt <= '0;
        // Result is captured from the post-beat value so OUT is entered on this same edge.
        for (int c = 0; c < N_COL; c++) o_data[c*ACC_W +: ACC_W] <= res[c];
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fc_engine_param.sv
// Bench for fc_engine_param: a 44-bit and a 12-bit accumulator instance share stimulus,
// each with its own expected-result queue checked by an output monitor.
module tb_fc_engine_param;

  localparam int N_COL = 4;
  localparam int KW    = 8;
  localparam int DW    = 4;
  localparam int CNT_W = 7;
  localparam int AW    = 44;
  localparam int AWS   = 12;
  localparam int OW    = N_COL * AW;
  localparam int OWS   = N_COL * AWS;

  logic                  clk = 1'b0;
  logic                  rst_fsm = 1'b0;
  logic                  start = 1'b0;
  logic [CNT_W:0]        n_in = '0;
  logic                  relu_en = 1'b0;
  logic [N_COL-1:0]      ckg_cmask = '0;
  logic                  in_valid = 1'b0;
  logic [DW-1:0]         i_data = '0;
  logic [N_COL*KW-1:0]   i_kernel = '0;
  logic                  out_ready = 1'b1;

  logic                  in_ready, out_valid, busy, done;
  logic [OW-1:0]         o_data;
  logic [CNT_W-1:0]      cnt;
  logic [1:0]            state_dbg;
  logic                  s_in_ready, s_out_valid, s_busy, s_done;
  logic [OWS-1:0]        s_o_data;
  logic [CNT_W-1:0]      s_cnt;
  logic [1:0]            s_state_dbg;

  int n_tests = 0;
  int n_fail  = 0;
  int n_done  = 0;
  int n_jobs  = 0;
  logic [OW-1:0]  exp_q[$];
  logic [OWS-1:0] exp_s_q[$];

  localparam logic [N_COL*KW-1:0] K_T1 = {8'sd0, 8'sd2, -8'sd1, 8'sd1};

  fc_engine_param #(.N_COL(N_COL), .KW(KW), .DW(DW), .ACC_W(AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_fsm(rst_fsm), .start(start), .n_in(n_in), .relu_en(relu_en),
    .ckg_cmask(ckg_cmask), .in_valid(in_valid), .in_ready(in_ready), .i_data(i_data),
    .i_kernel(i_kernel), .out_valid(out_valid), .out_ready(out_ready), .o_data(o_data),
    .busy(busy), .done(done), .cnt(cnt), .state_dbg(state_dbg)
  );

  fc_engine_param #(.N_COL(N_COL), .KW(KW), .DW(DW), .ACC_W(AWS), .CNT_W(CNT_W)) dut_sat (
    .clk(clk), .rst_fsm(rst_fsm), .start(start), .n_in(n_in), .relu_en(relu_en),
    .ckg_cmask(ckg_cmask), .in_valid(in_valid), .in_ready(s_in_ready), .i_data(i_data),
    .i_kernel(i_kernel), .out_valid(s_out_valid), .out_ready(out_ready), .o_data(s_o_data),
    .busy(s_busy), .done(s_done), .cnt(s_cnt), .state_dbg(s_state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [OW-1:0] pk(input int l0, input int l1, input int l2, input int l3);
    int l[4];
    l = '{l0, l1, l2, l3};
    pk = '0;
    for (int c = 0; c < N_COL; c++) pk[c*AW +: AW] = AW'(l[c]);
  endfunction

  function automatic logic [OWS-1:0] pks(input int l0, input int l1, input int l2, input int l3);
    int l[4];
    l = '{l0, l1, l2, l3};
    pks = '0;
    for (int c = 0; c < N_COL; c++) pks[c*AWS +: AWS] = AWS'(l[c]);
  endfunction

  function automatic logic [N_COL*KW-1:0] kall(input int k);
    kall = {N_COL{KW'(k)}};
  endfunction

  task automatic push(input int l0, input int l1, input int l2, input int l3);
    exp_q.push_back(pk(l0, l1, l2, l3));
    exp_s_q.push_back(pks(l0, l1, l2, l3));
    n_jobs++;
  endtask

  task automatic push_sep(input int m, input int s);
    exp_q.push_back(pk(m, m, m, m));
    exp_s_q.push_back(pks(s, s, s, s));
    n_jobs++;
  endtask

  // driver tasks
  task automatic wait_idle();
    int t = 0;
    while (busy && t < 400) begin
      @(posedge clk); #1;
      t++;
    end
    chk("idle_timeout", OW'(busy), OW'(0));
  endtask

  task automatic start_job(input int n, input logic relu, input logic [N_COL-1:0] mask);
    wait_idle();
    start = 1'b1; n_in = (CNT_W+1)'(n); relu_en = relu; ckg_cmask = mask;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_beat(input int idx, input logic [DW-1:0] d, input logic [N_COL*KW-1:0] k);
    int t = 0;
    i_data = d; i_kernel = k; in_valid = 1'b1;
    while (!in_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    chk("beat_ready", OW'(in_ready), OW'(1));
    chk("cnt", OW'(cnt), OW'(idx));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic run_t1(input logic relu, input logic [N_COL-1:0] mask);
    start_job(3, relu, mask);
    for (int i = 0; i < 3; i++) send_beat(i, DW'(i + 1), K_T1);
    wait_idle();
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_fsm) begin
      if (done) n_done++;
      if (done && !(out_valid && out_ready)) chk("done_spurious", OW'(done), OW'(0));
      if (out_valid) begin
        if (exp_q.size() == 0) chk("unexpected_out", OW'(out_valid), OW'(0));
        else begin
          chk("o_data", o_data, exp_q[0]);
          if (out_ready) begin
            chk("done_on_hs", OW'(done), OW'(1));
            void'(exp_q.pop_front());
          end
        end
      end
      if (s_out_valid) begin
        if (exp_s_q.size() == 0) chk("unexpected_out_sat", OW'(s_out_valid), OW'(0));
        else begin
          chk("o_data_sat", OW'(s_o_data), OW'(exp_s_q[0]));
          if (out_ready) void'(exp_s_q.pop_front());
        end
      end
    end
  end

  initial begin
    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", OW'(busy), OW'(0));
    chk("rst_in_ready", OW'(in_ready), OW'(0));
    chk("rst_out_valid", OW'(out_valid), OW'(0));
    chk("rst_done", OW'(done), OW'(0));
    chk("rst_cnt", OW'(cnt), OW'(0));
    chk("rst_o_data", o_data, OW'(0));
    chk("rst_state", OW'(state_dbg), OW'(0));
    rst_fsm = 1'b1;
    @(posedge clk); #1;

    // T1 basic, T2 relu and lane gating
    push(6, -6, 12, 0);   run_t1(1'b0, 4'b0000);
    push(6, 0, 12, 0);    run_t1(1'b1, 4'b0000);
    push(0, -6, 0, 0);    run_t1(1'b0, 4'b0101);

    // T3 bubbles, stray starts, downstream stall
    push(6, -6, 12, 0);
    out_ready = 1'b0;
    start_job(3, 1'b0, 4'b0000);
    send_beat(0, 4'd1, K_T1);
    start = 1'b1; n_in = 1; in_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    chk("t3_busy_acc", OW'(busy), OW'(1));
    send_beat(1, 4'd2, K_T1);
    @(posedge clk); #1;
    send_beat(2, 4'd3, K_T1);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    chk("t3_out_held", OW'(out_valid), OW'(1));
    out_ready = 1'b1;
    wait_idle();
    @(posedge clk); #1;
    chk("t3_stray_start_ignored", OW'(busy), OW'(0));

    // T4 long jobs and saturation, including recovery from a clamped value
    push_sep(243840, 2047);
    start_job(128, 1'b0, 4'b0000);
    for (int i = 0; i < 128; i++) send_beat(i, 4'd15, kall(127));
    wait_idle();
    chk("t4_cnt_cleared", OW'(cnt), OW'(0));
    push_sep(-245760, -2048);
    start_job(128, 1'b0, 4'b0000);
    for (int i = 0; i < 128; i++) send_beat(i, 4'd15, kall(-128));
    wait_idle();
    push_sep(1890, 127);
    start_job(3, 1'b0, 4'b0000);
    send_beat(0, 4'd15, kall(127));
    send_beat(1, 4'd15, kall(127));
    send_beat(2, 4'd15, kall(-128));
    wait_idle();

    // T5 reset mid-job, then rerun
    start_job(3, 1'b0, 4'b0000);
    send_beat(0, 4'd1, K_T1);
    send_beat(1, 4'd2, K_T1);
    rst_fsm = 1'b0;
    @(posedge clk); #1;
    chk("t5_busy", OW'(busy), OW'(0));
    chk("t5_in_ready", OW'(in_ready), OW'(0));
    chk("t5_out_valid", OW'(out_valid), OW'(0));
    chk("t5_cnt", OW'(cnt), OW'(0));
    chk("t5_o_data", o_data, OW'(0));
    rst_fsm = 1'b1;
    @(posedge clk); #1;
    push(6, -6, 12, 0);   run_t1(1'b0, 4'b0000);

    // T6 zero-length request ignored; minimum-latency single-beat job
    start_job(0, 1'b0, 4'b0000);
    chk("t6_n0_busy", OW'(busy), OW'(0));
    @(posedge clk); #1;
    chk("t6_n0_busy2", OW'(busy), OW'(0));
    push(-15, 0, 0, 0);
    i_data = 4'd15; i_kernel = {8'sd0, 8'sd0, 8'sd0, -8'sd1}; in_valid = 1'b1;
    start = 1'b1; n_in = 1; relu_en = 1'b0; ckg_cmask = '0;
    @(posedge clk); #1;
    start = 1'b0;
    chk("t6_ov_early", OW'(out_valid), OW'(0));
    chk("t6_in_ready", OW'(in_ready), OW'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("t6_ov_on_time", OW'(out_valid), OW'(1));
    wait_idle();

    // final report
    repeat (3) @(posedge clk);
    #1;
    chk("exp_q_empty", OW'(exp_q.size()), OW'(0));
    chk("exp_s_q_empty", OW'(exp_s_q.size()), OW'(0));
    chk("done_count", OW'(n_done), OW'(n_jobs));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
